mio_bus_arbiter: RTL and testbench
==================================

// Module: mio_bus_arbiter
// PURPOSE
//  Shares the data RAM and memory-mapped I/O (GPIO E/F, counter) between two bus masters:
//  M0 = SCPU data port, M1 = secondary master (program loader / DMA / debug).
//  Arbitrates, decodes address to the selected slave, inserts RAM wait states and returns
//  a one-cycle ready pulse (M0 ready drives SCPU MIO_ready). Sits between SCPU and RAM/IO.
// PARAMETERS
//  RAM_WAIT  1   extra WAIT cycles after ACCESS for RAM transfers (legal 0..7)
//  RAM_AW    10  RAM word-address width; ram_addr = addr[RAM_AW+1:2]
// PORTS
//  clk           in   1   system clock; all state on posedge
//  reset         in   1   asynchronous, active-high reset
//  m0_req        in   1   M0 request; held with addr/we/wdata until m0_ready
//  m0_we         in   4   M0 byte write enables (0 = read)
//  m0_addr       in   32  M0 byte address
//  m0_wdata      in   32  M0 write data
//  m0_rdata      out  32  M0 read data, valid with m0_ready, held until next M0 completion
//  m0_ready      out  1   M0 transfer complete (1-cycle pulse)
//  m1_req/m1_we/m1_addr/m1_wdata/m1_rdata/m1_ready   same as M0, for M1
//  grant         out  1   owner of current/last transfer (0 = M0, 1 = M1)
//  ram_wea       out  4   RAM byte write enables
//  ram_addr      out  RAM_AW  RAM word address
//  ram_din       out  32  RAM write data
//  ram_dout      in   32  RAM read data
//  io_wdata      out  32  write data to GPIO/counter
//  gpio_e_we     out  1   write strobe, region 0xE0000000
//  gpio_f_we     out  1   write strobe, 0xF0000000 (addr[2]=0)
//  counter_we    out  1   write strobe, 0xF0000004 (addr[2]=1)
//  gpio_rdata    in   32  GPIO read data (switches)
//  counter_rdata in   32  counter read data
// BEHAVIOUR
//  Reset: state=IDLE; all strobes, ready, ram_wea = 0; rdata regs = 0; grant = 0; last_grant = 1.
//  Decode on addr[31:28]: 4'hE -> GPIOE; 4'hF -> addr[2] ? COUNTER : GPIOF; else RAM.
//  FSM IDLE -> ACCESS -> {WAIT x RAM_WAIT, RAM only} -> DONE -> IDLE.
//   IDLE: no req -> stay. One req -> grant it. Both -> grant !last_grant (round-robin).
//         Latch master addr/we/wdata/region; update grant, last_grant.
//   ACCESS: 1 cycle. Drive ram_addr/ram_din/ram_wea or the one matching IO strobe
//         (only if we != 0). Strobes are high exactly this one cycle, never in WAIT/DONE.
//   WAIT: cnt counts RAM_WAIT-1 down to 0; ram_addr held; ram_wea = 0.
//   DONE: capture read data (RAM: ram_dout; GPIOE/F: gpio_rdata; COUNTER: counter_rdata)
//         into granted master's rdata; pulse its ready. Ungranted ready stays 0.
//  Latency, request seen in IDLE at cycle 0: IO ready in cycle 2; RAM in cycle 2+RAM_WAIT.
//  Min 3 cycles per transfer (DONE always returns to IDLE); a req held after ready is a new
//  transfer.
//  Writes also complete via DONE/ready; rdata unchanged on writes.
//  Master dropping req before ready: transfer still completes, ready still pulses.
//  Requests changing during ACCESS/WAIT are ignored (latched copy used).
//  Reset mid-transfer: strobes drop immediately (async), no ready issued, FSM to IDLE.
//  RAM_WAIT=0: ACCESS -> DONE directly.
//  addr bits above RAM_AW+1 ignored in RAM region; RAM wraps modulo 2^RAM_AW words.
// CONFIGURATION
//  MIO_FIXED_PRIO_EN defined: M0 always wins when both request (last_grant unused).
//   M1 may starve.
//  Not defined: round-robin as above; neither master waits more than one other transfer.
// TESTING
//  M0 write we=4'hF addr=0x00000010 data=0xDEADBEEF -> ram_wea=F, ram_addr=4 for 1 cycle;
//   m0_ready at cycle 3 (RAM_WAIT=1).
//  M0 read addr=0x10 -> m0_rdata=0xDEADBEEF with m0_ready; m1_ready stays 0.
//  M0 write 0xF0000004 data=5 -> counter_we=1 one cycle, io_wdata=5, ready cycle 2;
//   no RAM/GPIO strobe.
//  M0 and M1 both request continuously -> grant alternates 0,1,0,1;
//   with MIO_FIXED_PRIO_EN all go to M0.
//  Reset asserted during WAIT of RAM write -> ram_wea=0, no ready, next request served
//   from IDLE.
//  M1 read 0xE0000000 with gpio_rdata=0x0000A5A5 -> m1_rdata=0x0000A5A5;
//   RAM_WAIT=0 RAM read ready cycle 2.

Source files
------------

// File: rtl/mio_bus_arbiter.sv
// Two-master arbiter sharing data RAM and MMIO (GPIO E/F, counter), with RAM wait states.
// Build option: define MIO_FIXED_PRIO_EN for fixed M0 priority instead of round-robin.
module mio_bus_arbiter #(
    parameter int unsigned RAM_WAIT = 1,
    parameter int unsigned RAM_AW   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [3:0]        m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic [31:0]       m0_rdata,
    output logic              m0_ready,
    input  logic              m1_req,
    input  logic [3:0]        m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic [31:0]       m1_rdata,
    output logic              m1_ready,
    output logic              grant,
    output logic [3:0]        ram_wea,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic [31:0]       io_wdata,
    output logic              gpio_e_we,
    output logic              gpio_f_we,
    output logic              counter_we,
    input  logic [31:0]       gpio_rdata,
    input  logic [31:0]       counter_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;
    typedef enum logic [1:0] {RegRam, RegGpioE, RegGpioF, RegCounter} region_e;

    localparam bit         HasWait = (RAM_WAIT != 0);
    localparam logic [2:0] CntInit = (RAM_WAIT == 0) ? 3'd0 : 3'(RAM_WAIT - 1);

    state_e            state;
    region_e           region_q;
    logic              wr_q;
    logic [RAM_AW-1:0] word_q;
    logic [31:0]       wdata_q;
    logic [2:0]        cnt;
    logic [31:0]       m0_rdata_q;
    logic [31:0]       m1_rdata_q;

    logic        any_req;
    logic        pick_m1;
    logic [3:0]  sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    region_e     sel_region;
    logic [31:0] rd_src;
    logic        rd_live;

    assign any_req = m0_req | m1_req;

`ifdef MIO_FIXED_PRIO_EN
    assign pick_m1 = ~m0_req;
`else
    logic last_grant;
    // Contention goes to whoever did not own the previous transfer.
    assign pick_m1 = m1_req & (~m0_req | ~last_grant);
`endif

    assign sel_we    = pick_m1 ? m1_we    : m0_we;
    assign sel_addr  = pick_m1 ? m1_addr  : m0_addr;
    assign sel_wdata = pick_m1 ? m1_wdata : m0_wdata;

    always_comb begin
        if (sel_addr[31:28] == 4'hE) begin
            sel_region = RegGpioE;
        end else if (sel_addr[31:28] == 4'hF) begin
            sel_region = sel_addr[2] ? RegCounter : RegGpioF;
        end else begin
            sel_region = RegRam;
        end
    end

    always_comb begin
        case (region_q)
            RegGpioE, RegGpioF: rd_src = gpio_rdata;
            RegCounter:         rd_src = counter_rdata;
            default:            rd_src = ram_dout;
        endcase
    end

    // Read data is forwarded live during DONE so it is valid alongside ready.
    assign rd_live  = (state == StDone) && !wr_q;
    assign m0_rdata = (rd_live && !grant) ? rd_src : m0_rdata_q;
    assign m1_rdata = (rd_live &&  grant) ? rd_src : m1_rdata_q;

    assign ram_addr = word_q;
    assign ram_din  = wdata_q;
    assign io_wdata = wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            region_q   <= RegRam;
            wr_q       <= 1'b0;
            word_q     <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            grant      <= 1'b0;
`ifndef MIO_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            ram_wea    <= '0;
            gpio_e_we  <= 1'b0;
            gpio_f_we  <= 1'b0;
            counter_we <= 1'b0;
        end else begin
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
            ram_wea    <= '0;
            gpio_e_we  <= 1'b0;
            gpio_f_we  <= 1'b0;
            counter_we <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        state      <= StAccess;
                        grant      <= pick_m1;
`ifndef MIO_FIXED_PRIO_EN
                        last_grant <= pick_m1;
`endif
                        region_q   <= sel_region;
                        wr_q       <= |sel_we;
                        word_q     <= sel_addr[RAM_AW+1:2];
                        wdata_q    <= sel_wdata;
                        // Strobes are registered here so they are high for ACCESS only.
                        if (|sel_we) begin
                            unique case (sel_region)
                                RegRam:     ram_wea    <= sel_we;
                                RegGpioE:   gpio_e_we  <= 1'b1;
                                RegGpioF:   gpio_f_we  <= 1'b1;
                                RegCounter: counter_we <= 1'b1;
                            endcase
                        end
                    end
                end
                StAccess: begin
                    if (region_q == RegRam && HasWait) begin
                        state <= StWait;
                        cnt   <= CntInit;
                    end else begin
                        state    <= StDone;
                        m0_ready <= ~grant;
                        m1_ready <= grant;
                    end
                end
                StWait: begin
                    if (cnt == 3'd0) begin
                        state    <= StDone;
                        m0_ready <= ~grant;
                        m1_ready <= grant;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    if (!wr_q) begin
                        if (grant) begin
                            m1_rdata_q <= rd_src;
                        end else begin
                            m0_rdata_q <= rd_src;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    logic unused_addr;
    assign unused_addr = ^{sel_addr[27:RAM_AW+2], sel_addr[1:0]};

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Self-checking bench for mio_bus_arbiter: transfer-level reference model plus directed vectors.
module tb_mio_bus_arbiter;

    localparam int RW = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic m0_req = 1'b0, m1_req = 1'b0, w0_m0_req = 1'b0, w0_m1_req = 1'b0;
    logic [3:0] m0_we = '0, m1_we = '0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [31:0] gpio_rdata = 32'h0000A5A5, counter_rdata = 32'h00000777;

    logic [31:0] m0_rdata, m1_rdata, ram_din, io_wdata, ram_dout;
    logic        m0_ready, m1_ready, grant, gpio_e_we, gpio_f_we, counter_we;
    logic [3:0]  ram_wea;
    logic [9:0]  ram_addr;

    logic [31:0] w0_m0_rdata, w0_m1_rdata, w0_ram_din, w0_io_wdata, w0_ram_dout;
    logic        w0_m0_ready, w0_m1_ready, w0_grant, w0_gpio_e_we, w0_gpio_f_we, w0_counter_we;
    logic [3:0]  w0_ram_wea;
    logic [9:0]  w0_ram_addr;

    logic [31:0] ram [0:1023];
    logic [31:0] w0_ram [0:1023];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mio_bus_arbiter #(.RAM_WAIT(RW), .RAM_AW(10)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .grant(grant), .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .io_wdata(io_wdata), .gpio_e_we(gpio_e_we),
        .gpio_f_we(gpio_f_we), .counter_we(counter_we), .gpio_rdata(gpio_rdata),
        .counter_rdata(counter_rdata)
    );

    mio_bus_arbiter #(.RAM_WAIT(0), .RAM_AW(10)) dut_w0 (
        .clk(clk), .reset(reset),
        .m0_req(w0_m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(w0_m0_rdata), .m0_ready(w0_m0_ready),
        .m1_req(w0_m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(w0_m1_rdata), .m1_ready(w0_m1_ready),
        .grant(w0_grant), .ram_wea(w0_ram_wea), .ram_addr(w0_ram_addr), .ram_din(w0_ram_din),
        .ram_dout(w0_ram_dout), .io_wdata(w0_io_wdata), .gpio_e_we(w0_gpio_e_we),
        .gpio_f_we(w0_gpio_f_we), .counter_we(w0_counter_we), .gpio_rdata(gpio_rdata),
        .counter_rdata(counter_rdata)
    );

    // Synchronous RAMs with registered read data.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_wea[b]) ram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            if (w0_ram_wea[b]) w0_ram[w0_ram_addr][8*b +: 8] <= w0_ram_din[8*b +: 8];
        end
        ram_dout    <= ram[ram_addr];
        w0_ram_dout <= w0_ram[w0_ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int region_of(input logic [31:0] a);
        if (a[31:28] == 4'hE) return 1;
        if (a[31:28] == 4'hF) return a[2] ? 3 : 2;
        return 0;
    endfunction

    // Reference model: phase counts cycles since the grant; phase==plen is the ready cycle.
    int          phase = 0;
    int          plen = 2;
    bit          cur_m = 1'b0;
    int          cur_region = 0;
    logic [3:0]  cur_we = '0;
    logic [31:0] cur_addr = '0, cur_wdata = '0;
    bit          mgrant = 1'b0, mlast = 1'b1;
    logic [31:0] exp_rd [0:1];
    logic [31:0] mmem [0:1023];

    initial begin
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            phase = 0; mgrant = 1'b0; mlast = 1'b1;
            exp_rd[0] = '0; exp_rd[1] = '0;
        end else if (phase == 0) begin
            if (m0_req || m1_req) begin
`ifdef MIO_FIXED_PRIO_EN
                cur_m = !m0_req;
`else
                cur_m = (m0_req && m1_req) ? !mlast : m1_req;
`endif
                mgrant = cur_m; mlast = cur_m;
                cur_we = cur_m ? m1_we : m0_we;
                cur_addr = cur_m ? m1_addr : m0_addr;
                cur_wdata = cur_m ? m1_wdata : m0_wdata;
                cur_region = region_of(cur_addr);
                plen = (cur_region == 0) ? 2 + RW : 2;
                phase = 1;
                if (cur_region == 0)
                    for (int b = 0; b < 4; b++)
                        if (cur_we[b]) mmem[cur_addr[11:2]][8*b +: 8] = cur_wdata[8*b +: 8];
            end
        end else if (phase == plen) begin
            phase = 0;
        end else begin
            phase++;
            if (phase == plen && cur_we == 4'h0)
                exp_rd[cur_m] = (cur_region == 0) ? mmem[cur_addr[11:2]] :
                                (cur_region == 3) ? counter_rdata : gpio_rdata;
        end
    end

    always @(negedge clk) begin
        bit acc;
        acc = (phase == 1);
        chk("m0_ready", {31'd0, m0_ready}, {31'd0, phase == plen && !cur_m});
        chk("m1_ready", {31'd0, m1_ready}, {31'd0, phase == plen && cur_m});
        chk("grant", {31'd0, grant}, {31'd0, mgrant});
        chk("ram_wea", {28'd0, ram_wea}, {28'd0, (acc && cur_region == 0) ? cur_we : 4'h0});
        chk("gpio_e_we", {31'd0, gpio_e_we}, {31'd0, acc && cur_we != 0 && cur_region == 1});
        chk("gpio_f_we", {31'd0, gpio_f_we}, {31'd0, acc && cur_we != 0 && cur_region == 2});
        chk("counter_we", {31'd0, counter_we}, {31'd0, acc && cur_we != 0 && cur_region == 3});
        if (phase != 0 && cur_region == 0) chk("ram_addr", {22'd0, ram_addr}, {22'd0, cur_addr[11:2]});
        if (acc && cur_we != 0) chk("wdata", (cur_region == 0) ? ram_din : io_wdata, cur_wdata);
        chk("m0_rdata", m0_rdata, exp_rd[0]);
        chk("m1_rdata", m1_rdata, exp_rd[1]);
    end

    int rdy_cnt1 = 0, rdy_cnt0 = 0, wea_cnt = 0, c_cnt = 0, ef_cnt = 0, w0_io_cnt = 0;
    logic [31:0] last_io = '0, last_wea_addr = '0;
    logic [3:0]  last_wea = '0;

    always @(negedge clk) begin
        if (m0_ready) rdy_cnt0++;
        if (m1_ready) rdy_cnt1++;
        if (ram_wea != 4'h0) begin wea_cnt++; last_wea_addr = {22'd0, ram_addr}; last_wea = ram_wea; end
        if (counter_we) begin c_cnt++; last_io = io_wdata; end
        if (gpio_e_we || gpio_f_we) ef_cnt++;
        if (w0_gpio_e_we || w0_gpio_f_we || w0_counter_we) w0_io_cnt++;
    end

    // Starts at posedge+1 with the DUT idle; returns at posedge+1 after the ready pulse.
    task automatic xfer(input bit inst, input bit m, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rd);
        if (m) begin m1_we = we; m1_addr = addr; m1_wdata = wdata; end
        else begin m0_we = we; m0_addr = addr; m0_wdata = wdata; end
        if (inst) begin if (m) w0_m1_req = 1'b1; else w0_m0_req = 1'b1; end
        else begin if (m) m1_req = 1'b1; else m0_req = 1'b1; end
        lat = -1;
        rd = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (inst ? (m ? w0_m1_ready : w0_m0_ready) : (m ? m1_ready : m0_ready)) begin
                lat = n;
                rd = inst ? (m ? w0_m1_rdata : w0_m0_rdata) : (m ? m1_rdata : m0_rdata);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0; w0_m0_req = 1'b0; w0_m1_req = 1'b0;
        if (lat < 0) chk("xfer_timeout", 32'd0, 32'd1);
    endtask

    initial begin : stim
        int lat, ng, s0, s1, s2;
        logic [31:0] rd;
        logic [31:0] gseq [0:3];
        logic [31:0] exp_g [0:3];
`ifdef MIO_FIXED_PRIO_EN
        exp_g = '{32'd0, 32'd0, 32'd0, 32'd0};
`else
        exp_g = '{32'd0, 32'd1, 32'd0, 32'd1};
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
        chk("rst_ram_wea", {28'd0, ram_wea}, 32'd0);
        chk("rst_grant", {31'd0, grant}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);

        s0 = wea_cnt;
        xfer(0, 0, 4'hF, 32'h00000010, 32'hDEADBEEF, lat, rd);
        chk("ram_wr_lat", lat, 3);
        chk("ram_wr_wea_cycles", wea_cnt - s0, 1);
        chk("ram_wr_addr", last_wea_addr, 32'd4);
        chk("ram_wr_wea", {28'd0, last_wea}, 32'hF);

        s1 = rdy_cnt1;
        xfer(0, 0, 4'h0, 32'h00000010, 32'd0, lat, rd);
        chk("ram_rd_lat", lat, 3);
        chk("ram_rd_data", rd, 32'hDEADBEEF);
        chk("ram_rd_no_m1_ready", rdy_cnt1 - s1, 0);

        s0 = wea_cnt; s1 = c_cnt; s2 = ef_cnt;
        xfer(0, 0, 4'hF, 32'hF0000004, 32'd5, lat, rd);
        chk("cnt_wr_lat", lat, 2);
        chk("cnt_wr_strobes", c_cnt - s1, 1);
        chk("cnt_wr_io_wdata", last_io, 32'd5);
        chk("cnt_wr_no_ram", wea_cnt - s0, 0);
        chk("cnt_wr_no_gpio", ef_cnt - s2, 0);

        xfer(0, 1, 4'b0011, 32'h00000010, 32'hAAAABBBB, lat, rd);
        chk("byte_wr_lat", lat, 3);
        xfer(0, 0, 4'h0, 32'h00000010, 32'd0, lat, rd);
        chk("byte_rd_data", rd, 32'hDEADBBBB);

        xfer(0, 1, 4'hF, 32'h00001014, 32'hCAFEF00D, lat, rd);
        chk("wrap_wr_addr", last_wea_addr, 32'd5);
        xfer(0, 0, 4'h0, 32'h00000014, 32'd0, lat, rd);
        chk("wrap_rd_data", rd, 32'hCAFEF00D);

        xfer(0, 1, 4'h0, 32'hE0000000, 32'd0, lat, rd);
        chk("gpio_rd_lat", lat, 2);
        chk("gpio_rd_data", rd, 32'h0000A5A5);

        m0_we = 4'h0; m0_addr = 32'hE0000000; m1_we = 4'h0; m1_addr = 32'hF0000000;
        m0_req = 1'b1; m1_req = 1'b1;
        ng = 0;
        for (int n = 0; n < 40 && ng < 4; n++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin gseq[ng] = {31'd0, grant}; ng++; end
        end
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        chk("arb_count", ng, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("arb_grant%0d", i), gseq[i], exp_g[i]);

        m0_we = 4'hF; m0_addr = 32'hF0000000; m0_wdata = 32'h77; m0_req = 1'b1;
        @(posedge clk); #1;
        chk("acc_gpio_f_we", {31'd0, gpio_f_we}, 32'd1);
        #2 reset = 1'b1; m0_req = 1'b0;
        #1 chk("async_clear_strobe", {31'd0, gpio_f_we}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        s0 = rdy_cnt0;
        m0_we = 4'hF; m0_addr = 32'h00000020; m0_wdata = 32'h12345678; m0_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b1; m0_req = 1'b0;
        #1 chk("wait_rst_wea", {28'd0, ram_wea}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("wait_rst_no_ready", rdy_cnt0 - s0, 0);
        chk("wait_rst_rdata", m0_rdata, 32'd0);
        xfer(0, 0, 4'h0, 32'h00000020, 32'd0, lat, rd);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_data", rd, 32'h12345678);

        xfer(1, 0, 4'hF, 32'h00000040, 32'h0BADC0DE, lat, rd);
        chk("w0_wr_lat", lat, 2);
        xfer(1, 1, 4'h0, 32'h00000040, 32'd0, lat, rd);
        chk("w0_rd_lat", lat, 2);
        chk("w0_rd_data", rd, 32'h0BADC0DE);
        chk("w0_grant", {31'd0, w0_grant}, 32'd1);
        chk("w0_no_io", w0_io_cnt, 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
